pe64_request_scheduler: RTL and testbench

- Sequential wrapper that accumulates 64 sticky request lines into a pending register.
- Each cycle it selects the highest-index pending request with a 64-input priority encoder.
- It issues that index to a downstream consumer through a registered valid/ready port, and clears the pending bit on acceptance.
- Sits directly downstream of the request sources and feeds encoded indices to the service logic (interrupt/service dispatcher).

---
 rtl/pe_pkg.sv | 31 +++
 rtl/pe64_lookahead.sv | 56 +++++
 rtl/pe64_request_scheduler.sv | 118 +++++++++++
 tb/tb_pe64_request_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared constants and helpers for the 64-line priority-encoded request
// scheduler and its lookahead encoder.
//   N          : number of request lines
//   IDX_W      : width of an encoded index (log2 N)
//   CNT_W      : width of a population count of N bits (0..N)
//   GROUP_W    : request bits per encoder group
//   NUM_GROUPS : number of encoder groups
//   GRP_W      : width of a group number
//   COL_W      : width of a column number inside a group
//   onehot64() : expands an index into a 64-bit one-hot mask
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int N          = 64;
    localparam int IDX_W      = 6;
    localparam int CNT_W      = IDX_W + 1;
    localparam int GROUP_W    = 4;
    localparam int NUM_GROUPS = 16;
    localparam int GRP_W      = 4;
    localparam int COL_W      = 2;

    function automatic logic [N-1:0] onehot64(input logic [IDX_W-1:0] idx);
        logic [N-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage : pe_pkg

// File: rtl/pe64_lookahead.sv
// ---------------------------------------------------------------------------
// pe64_lookahead
// Combinational 64-input priority encoder; the highest set bit wins.
// Built as a two-level lookahead: 16 four-bit group ORs select the highest
// active group, then a 4-way column encode picks the bit inside that group.
// Ports:
//   d   : input  [63:0] request vector
//   v   : output        at least one bit of d is set
//   idx : output [5:0]  index of the highest set bit (0 when d is zero)
// ---------------------------------------------------------------------------
module pe64_lookahead
    import pe_pkg::*;
(
    input  logic [N-1:0]     d,
    output logic             v,
    output logic [IDX_W-1:0] idx
);

    logic [NUM_GROUPS-1:0] group_or;
    logic [GRP_W-1:0]      grp_sel;
    logic [GROUP_W-1:0]    nibble;
    logic [COL_W-1:0]      col;

    always_comb begin
        group_or = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            group_or[g] = |d[g*GROUP_W +: GROUP_W];
        end
    end

    // Ascending scan so the last (highest) active group overwrites the
    // lower ones.
    always_comb begin
        grp_sel = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (group_or[g]) begin
                grp_sel = GRP_W'(g);
            end
        end
    end

    assign nibble = d[{grp_sel, 2'b00} +: GROUP_W];

    always_comb begin
        casez (nibble)
            4'b1???: col = 2'd3;
            4'b01??: col = 2'd2;
            4'b001?: col = 2'd1;
            default: col = 2'd0;
        endcase
    end

    assign v   = |group_or;
    assign idx = {grp_sel, col};

endmodule : pe64_lookahead

// File: rtl/pe64_request_scheduler.sv
// ---------------------------------------------------------------------------
// pe64_request_scheduler
// Accumulates 64 sticky request lines into a pending register and issues
// the highest pending index through a single registered valid/ready slot.
// A pending bit is cleared on the edge its index is accepted, unless the
// same bit is being set again in that cycle.
// Ports:
//   clk       : input         rising-edge clock
//   rst_n     : input         asynchronous active-low reset
//   req_set   : input  [63:0] one-cycle set mask OR'd into pending
//   flush     : input         synchronous clear of pending and output slot
//   out_valid : output        issued index is valid
//   out_ready : input         consumer accepts when out_valid & out_ready
//   out_idx   : output [5:0]  issued index
//   pending   : output [63:0] pending register
//   pend_cnt  : output [6:0]  population count of pending
//   busy      : output        pending non-empty or slot occupied
// ---------------------------------------------------------------------------
module pe64_request_scheduler
    import pe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_set,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             busy
);

    logic [N-1:0]     pending_q,   pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q,   out_idx_d;
    logic [CNT_W-1:0] pend_cnt_q,  pend_cnt_d;
    logic             busy_q,      busy_d;

    logic             accept;
    logic             load;
    logic [N-1:0]     clr_mask;
    logic [N-1:0]     cand;
    logic             enc_v;
    logic [IDX_W-1:0] enc_idx;

    assign accept   = out_valid_q & out_ready;
    assign load     = ~out_valid_q | accept;
    assign clr_mask = accept ? onehot64(out_idx_q) : '0;

    // The index being accepted this cycle is masked out so it cannot be
    // re-issued from the not-yet-updated pending value.
    assign cand = pending_q & ~clr_mask;

    pe64_lookahead u_enc (
        .d   (cand),
        .v   (enc_v),
        .idx (enc_idx)
    );

    // Set is applied after clear, so a re-request of the accepted bit
    // survives and gets issued again later.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | req_set;
        if (flush) begin
            pending_d = '0;
        end
    end

    // Slot loads only when empty or draining; a stalled index is never
    // pre-empted by a higher request. out_idx keeps its last value when
    // nothing is loaded.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = enc_v;
            if (enc_v) begin
                out_idx_d = enc_idx;
            end
        end
    end

    // Status outputs come from next-state values so they line up with the
    // registered pending and slot contents.
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            pend_cnt_d = pend_cnt_d + CNT_W'(pending_d[i]);
        end
        busy_d = (|pending_d) | out_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            pend_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            pend_cnt_q  <= pend_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign pending   = pending_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pend_cnt  = pend_cnt_q;
    assign busy      = busy_q;

endmodule : pe64_request_scheduler

// File: tb/tb_pe64_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pe64_request_scheduler
// Directed bench for pe64_request_scheduler. Stimulus pushes the indices
// it expects to see accepted into a queue; a separate monitor pops and
// compares on every accepted transfer. Register-level status is checked
// directly from the stimulus thread against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pe64_request_scheduler;

    logic        clk;
    logic        rst_n;
    logic [63:0] req_set;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic [63:0] pending;
    logic [6:0]  pend_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    pe64_request_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_set   (req_set),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .pend_cnt  (pend_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: every accepted transfer must match the next expected index.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL issue_unexpected got=%0d want=none", out_idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (out_idx !== 6'(e)) begin
                    bad++;
                    $display("[TB] FAIL issue got=%0d want=%0d", out_idx, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [63:0] req, input logic fl,
                                 input logic rdy);
        req_set   = req;
        flush     = fl;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got,
                               input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"},    64'(out_valid), 64'd0);
        checkOutput({tag, "_pending"},  pending,        64'd0);
        checkOutput({tag, "_pend_cnt"}, 64'(pend_cnt),  64'd0);
        checkOutput({tag, "_busy"},     64'(busy),      64'd0);
    endtask

    int          pri_idx [4] = '{63, 40, 17, 0};
    int          pri_cnt [4] = '{4, 3, 2, 1};
    logic [63:0] all_ones;

    initial begin
        all_ones = '1;
        rst_n    = 1'b0;
        applyStimulus(64'd0, 1'b0, 1'b0);

        // Reset then idle
        #3;
        checkIdle("in_reset");
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checkIdle("idle");
        end

        // Single request, two-cycle latency, one-cycle valid
        applyStimulus(64'd1 << 5, 1'b0, 1'b1);
        exp_q.push_back(5);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b1);
        checkOutput("single_pend",     pending,          64'd1 << 5);
        checkOutput("single_valid0",   64'(out_valid),   64'd0);
        checkOutput("single_cnt",      64'(pend_cnt),    64'd1);
        checkOutput("single_busy",     64'(busy),        64'd1);
        tick();
        checkOutput("single_valid1",   64'(out_valid),   64'd1);
        checkOutput("single_idx",      64'(out_idx),     64'd5);
        checkOutput("single_pend_hold", pending,         64'd1 << 5);
        tick();
        checkIdle("single_after");

        // Priority order 63,40,17,0 back to back
        applyStimulus((64'd1 << 0) | (64'd1 << 17) | (64'd1 << 40) | (64'd1 << 63),
                      1'b0, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(pri_idx[i]);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b1);
        checkOutput("prio_cnt_load", 64'(pend_cnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("prio_valid", 64'(out_valid), 64'd1);
            checkOutput("prio_idx",   64'(out_idx),   64'(pri_idx[i]));
            checkOutput("prio_cnt",   64'(pend_cnt),  64'(pri_cnt[i]));
        end
        tick();
        checkIdle("prio_after");

        // Stall: held index is not pre-empted by a higher request
        applyStimulus(64'd1 << 3, 1'b0, 1'b0);
        exp_q.push_back(3);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b0);
        tick();
        checkOutput("stall_idx0", 64'(out_idx), 64'd3);
        applyStimulus(64'd1 << 50, 1'b0, 1'b0);
        exp_q.push_back(50);
        for (int c = 0; c < 4; c++) begin
            tick();
            applyStimulus(64'd0, 1'b0, 1'b0);
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_idx",   64'(out_idx),   64'd3);
        end
        checkOutput("stall_pend", pending,        (64'd1 << 3) | (64'd1 << 50));
        checkOutput("stall_cnt",  64'(pend_cnt),  64'd2);
        applyStimulus(64'd0, 1'b0, 1'b1);
        tick();
        checkOutput("stall_next_idx", 64'(out_idx),   64'd50);
        checkOutput("stall_next_vld", 64'(out_valid), 64'd1);
        tick();
        checkIdle("stall_after");

        // Re-arm on accept: bit 9 set again in its own acceptance cycle
        applyStimulus((64'd1 << 9) | (64'd1 << 20), 1'b0, 1'b1);
        exp_q.push_back(20);
        exp_q.push_back(9);
        exp_q.push_back(30);
        exp_q.push_back(9);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b1);
        tick();
        checkOutput("rearm_idx20", 64'(out_idx), 64'd20);
        tick();
        checkOutput("rearm_idx9", 64'(out_idx), 64'd9);
        applyStimulus((64'd1 << 9) | (64'd1 << 30), 1'b0, 1'b1);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b1);
        checkOutput("rearm_pend",  pending,         (64'd1 << 9) | (64'd1 << 30));
        checkOutput("rearm_valid", 64'(out_valid),  64'd0);
        tick();
        checkOutput("rearm_idx30", 64'(out_idx), 64'd30);
        tick();
        checkOutput("rearm_idx9b", 64'(out_idx), 64'd9);
        tick();
        checkIdle("rearm_after");

        // Flush overrides a simultaneous set
        applyStimulus(all_ones, 1'b0, 1'b0);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b0);
        checkOutput("full_cnt", 64'(pend_cnt), 64'd64);
        tick();
        checkOutput("full_idx",   64'(out_idx),   64'd63);
        checkOutput("full_valid", 64'(out_valid), 64'd1);
        applyStimulus(64'd1 << 2, 1'b1, 1'b0);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b0);
        checkIdle("flush");

        // All 64 bits drain in order 63 down to 0
        applyStimulus(all_ones, 1'b0, 1'b1);
        for (int i = 63; i >= 0; i--) exp_q.push_back(i);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b1);
        for (int i = 63; i >= 0; i--) begin
            tick();
            checkOutput("drain_cnt", 64'(pend_cnt), 64'(i + 1));
        end
        tick();
        checkIdle("drain_after");

        // Async reset mid-stall clears without a clock edge
        applyStimulus(64'd1 << 7, 1'b0, 1'b0);
        tick();
        applyStimulus(64'd0, 1'b0, 1'b0);
        tick();
        checkOutput("arst_pre_valid", 64'(out_valid), 64'd1);
        checkOutput("arst_pre_idx",   64'(out_idx),   64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("arst");
        checkOutput("arst_idx", 64'(out_idx), 64'd0);
        #3;
        rst_n = 1'b1;
        tick();
        checkIdle("arst_after");

        repeat (3) tick();
        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pe64_request_scheduler
